// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
package fifo_pkg;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int AE_LVL = 2;
    localparam int AF_LVL = 2;

    typedef logic [WIDTH-1:0]         word_t;
    typedef logic [$clog2(DEPTH)-1:0] ptr_t;
    typedef logic [$clog2(DEPTH):0]   cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage with a synchronous write port and a registered read port.
// The read register holds its value unless a read is requested.
module fifo_mem
    import fifo_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  we_i,
    input  ptr_t  waddr_i,
    input  word_t wdata_i,
    input  logic  re_i,
    input  ptr_t  raddr_i,
    output word_t rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;
    word_t rdata_d;

    // Next read data: load the addressed word on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Read data register; cleared by reset, contents of the array are not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with push/pop handshake, occupancy flags and an
// error pulse for rejected requests. reset_n is active-high despite its name.
module fifo
    import fifo_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             full,
    output logic             error
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("fifo: DEPTH must be a power of 2");
    end
    if (!(AE_LVL >= 0 && AE_LVL < DEPTH - AF_LVL && DEPTH - AF_LVL <= DEPTH)) begin : g_lvl_chk
        $error("fifo: need 0 <= AE_LVL < DEPTH-AF_LVL <= DEPTH");
    end

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic error_q, error_d;
    logic push_ok;
    logic pop_ok;

    // Flags decode the registered count.
    assign empty        = (count_q == '0);
    assign full         = (count_q == cnt_t'(DEPTH));
    assign almost_empty = (count_q <= cnt_t'(AE_LVL));
    assign almost_full  = (count_q >= cnt_t'(DEPTH - AF_LVL));
    assign error        = error_q;

    // Accept decisions, pointer/count next state and error detection.
    always_comb begin
        pop_ok   = pop && !empty;
        // A full FIFO still takes a push when a pop frees a slot in the same cycle.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = (push && !push_ok) || (pop && !pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    fifo_mem u_mem (
        .clk_i   (clk),
        .rst_i   (reset_n),
        .we_i    (push_ok && !reset_n),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (pop_ok && !reset_n),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus a randomized run, all
// compared against a queue-based reference model.
module tb_fifo;
    import fifo_pkg::*;

    logic  clk = 1'b0;
    logic  reset_n = 1'b1;
    logic  push = 1'b0;
    logic  pop = 1'b0;
    word_t data_in = '0;
    word_t data_out;
    logic  empty, almost_empty, almost_full, full, error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    word_t model_q[$];
    word_t model_dout = '0;
    logic  model_err = 1'b0;

    fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .full         (full),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic step(input logic r, input logic pu, input logic po, input word_t d);
        logic pop_ok, push_ok;
        reset_n = r;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_dout = '0;
            model_err  = 1'b0;
        end else begin
            pop_ok  = po && (model_q.size() > 0);
            push_ok = pu && ((model_q.size() < DEPTH) || pop_ok);
            model_err = (pu && !push_ok) || (po && !pop_ok);
            if (pop_ok) model_dout = model_q.pop_front();
            if (push_ok) model_q.push_back(d);
        end
        @(negedge clk);
        reset_n = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, word_t'(i));
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({empty, almost_empty, full, almost_full, error} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 11000", {empty, almost_empty, full,
                     almost_full, error});
        end
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL reset_dout: got %0h expected 0", data_out);
        end
    endtask

    task automatic test_push_pop();
        word_t vals[3] = '{word_t'(11), word_t'(22), word_t'(33)};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, vals[i]);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (data_out !== vals[i] || data_out !== model_dout) begin
                errors++;
                $display("FAIL push_pop_dout[%0d]: got %0d expected %0d", i, data_out, vals[i]);
            end
        end
        checks++;
        if (empty !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_end: got empty=%b error=%b expected empty=1 error=0",
                     empty, error);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, word_t'(i));
            checks++;
            if (almost_full !== (i + 1 >= DEPTH - AF_LVL) || full !== (i + 1 == DEPTH)) begin
                errors++;
                $display("FAIL fill_flags[%0d]: got af=%b full=%b expected af=%b full=%b", i,
                         almost_full, full, (i + 1 >= DEPTH - AF_LVL), (i + 1 == DEPTH));
            end
        end
        step(1'b0, 1'b1, 1'b0, word_t'(99));
        checks++;
        if (error !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_err: got error=%b full=%b expected 1 1", error, full);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err_clear: got %b expected 0", error);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (data_out !== word_t'(i)) begin
                errors++;
                $display("FAIL fill_drain[%0d]: got %0d expected %0d", i, data_out, i);
            end
        end
        checks++;
        if (empty !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain_end: got empty=%b error=%b expected 1 0", empty, error);
        end
    endtask

    task automatic test_pop_empty();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (error !== 1'b1 || data_out !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got error=%b dout=%0h empty=%b expected 1 0 1",
                     error, data_out, empty);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (error !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_clear: got error=%b empty=%b expected 0 1", error, empty);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, word_t'(200 + i));
        step(1'b0, 1'b1, 1'b1, word_t'(100));
        checks++;
        if (data_out !== word_t'(200) || full !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: got dout=%0d full=%b error=%b expected 200 1 0",
                     data_out, full, error);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (data_out !== ((i == DEPTH - 1) ? word_t'(100) : word_t'(201 + i))) begin
                errors++;
                $display("FAIL wrap_drain[%0d]: got %0d expected %0d", i, data_out,
                         (i == DEPTH - 1) ? 100 : 201 + i);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        step(1'b0, 1'b1, 1'b1, word_t'(5));
        checks++;
        if (error !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL empty_push_pop: got error=%b empty=%b expected 1 0", error, empty);
        end
        step(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (data_out !== word_t'(5) || error !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_push_pop_read: got dout=%0d error=%b empty=%b expected 5 0 1",
                     data_out, error, empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, word_t'(300 + i));
        step(1'b1, 1'b1, 1'b1, word_t'(777));
        checks++;
        if ({empty, almost_empty, almost_full, full} !== 4'b1100 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_mid: got flags=%b dout=%0h expected 1100 0",
                     {empty, almost_empty, almost_full, full}, data_out);
        end
        step(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (error !== 1'b1 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_pop: got error=%b dout=%0h expected 1 0", error, data_out);
        end
    endtask

    task automatic test_random();
        logic r, pu, po;
        int sz;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            // Bias toward filling or draining in phases so both ends are reached.
            pu = ($urandom_range(0, 99) < (((n / 200) % 2 == 0) ? 70 : 30));
            po = ($urandom_range(0, 99) < (((n / 200) % 2 == 0) ? 30 : 70));
            step(r, pu, po, word_t'($urandom()));
            sz = model_q.size();
            checks++;
            if (data_out !== model_dout || error !== model_err) begin
                errors++;
                $display("FAIL random_data[%0d]: got dout=%0h err=%b expected dout=%0h err=%b",
                         n, data_out, error, model_dout, model_err);
            end
            checks++;
            if (empty !== (sz == 0) || full !== (sz == DEPTH) || almost_empty !== (sz <= AE_LVL)
                || almost_full !== (sz >= DEPTH - AF_LVL)) begin
                errors++;
                $display("FAIL random_flags[%0d]: got e=%b ae=%b af=%b f=%b for count %0d",
                         n, empty, almost_empty, almost_full, full, sz);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_fill();
        test_pop_empty();
        test_full_push_pop();
        test_empty_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
